// File: rtl/pwm_regs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_regs_pkg
//  Description : PWM register-file address map and ramp sequencer FSM states
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_regs_pkg;

  // Register-file byte addresses
  localparam logic [5:0] REG_PERIOD        = 6'h00;
  localparam logic [5:0] REG_COUNTER_EN    = 6'h02;
  localparam logic [5:0] REG_COMPARE1_LO   = 6'h03;
  localparam logic [5:0] REG_COMPARE1_HI   = 6'h04;
  localparam logic [5:0] REG_COMPARE2_LO   = 6'h05;
  localparam logic [5:0] REG_COMPARE2_HI   = 6'h06;
  localparam logic [5:0] REG_COUNTER_RESET = 6'h07;
  localparam logic [5:0] REG_COUNTER_VAL   = 6'h08;
  localparam logic [5:0] REG_PRESCALE      = 6'h0A;
  localparam logic [5:0] REG_UPNOTDOWN     = 6'h0B;
  localparam logic [5:0] REG_PWM_EN        = 6'h0C;
  localparam logic [5:0] REG_FUNCTIONS     = 6'h0D;

  // Ramp sequencer FSM encoding
  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_WR_LO = 3'd1;
  localparam state_t S_WR_HI = 3'd2;
  localparam state_t S_WAIT  = 3'd3;
  localparam state_t S_STEP  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/pwm_ramp_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_ramp_sequencer_if
//  Description : Single-cycle byte write bus (strobe, address, data)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_ramp_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (output we, output addr, output data);
  modport slave  (input  we, input  addr, input  data);
endinterface
`default_nettype wire

// File: rtl/reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bus_arbiter
//  Description : Two-requester fixed-priority write mux, host over sequencer,
//                registered bus output with combinational grant to sequencer
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_bus_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              host_we_i,
  input  wire logic [ADDR_W-1:0] host_addr_i,
  input  wire logic [DATA_W-1:0] host_data_i,
  input  wire logic              seq_req_i,
  input  wire logic [ADDR_W-1:0] seq_addr_i,
  input  wire logic [DATA_W-1:0] seq_data_i,
  output logic                   seq_gnt_o,
  output logic                   reg_we_o,
  output logic [ADDR_W-1:0]      reg_addr_o,
  output logic [DATA_W-1:0]      reg_data_o
);

  logic              reg_we_q;
  logic [ADDR_W-1:0] reg_addr_q;
  logic [DATA_W-1:0] reg_data_q;

  // The sequencer only wins a cycle in which the host is silent
  always_comb begin
    seq_gnt_o = seq_req_i && !host_we_i;
  end

  // Register the winning request so the bus is driven one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_we_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
    end else if (host_we_i) begin
      reg_we_q   <= 1'b1;
      reg_addr_q <= host_addr_i;
      reg_data_q <= host_data_i;
    end else if (seq_req_i) begin
      reg_we_q   <= 1'b1;
      reg_addr_q <= seq_addr_i;
      reg_data_q <= seq_data_i;
    end else begin
      reg_we_q   <= 1'b0;
    end
  end

  assign reg_we_o   = reg_we_q;
  assign reg_addr_o = reg_addr_q;
  assign reg_data_o = reg_data_q;

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_ramp_sequencer
//  Description : Steps compare1 from a start to an end value, one step every
//                cfg_hold+1 PWM periods, through byte writes on the shared
//                register-file bus (host writes always win)
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_ramp_sequencer
  import pwm_regs_pkg::*;
#(
  parameter int              ADDR_W      = 6,
  parameter int              DATA_W      = 8,
  parameter logic [ADDR_W-1:0] CMP_LO_ADDR = 6'h03,
  parameter logic [ADDR_W-1:0] CMP_HI_ADDR = 6'h04,
  parameter int              HOLD_W      = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  pwm_ramp_sequencer_if.slave    host_bus,
  pwm_ramp_sequencer_if.master   reg_bus,
  input  wire logic              period_wrap_i,
  input  wire logic              ramp_start_i,
  input  wire logic              ramp_stop_i,
  input  wire logic [15:0]       cfg_start_i,
  input  wire logic [15:0]       cfg_end_i,
  input  wire logic [15:0]       cfg_step_i,
  input  wire logic [HOLD_W-1:0] cfg_hold_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   aborted_o,
  output logic [15:0]            cur_value_o
);

  state_t            state_q,     state_d;
  logic [15:0]       value_q,     value_d;
  logic [15:0]       end_q,       end_d;
  logic [15:0]       step_q,      step_d;
  logic [HOLD_W-1:0] hold_cfg_q,  hold_cfg_d;
  logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic              dir_up_q,    dir_up_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              aborted_q,   aborted_d;
  logic [15:0]       cur_value_q, cur_value_d;

  logic              w_host_ovr;
  logic              w_abort;
  logic              w_seq_req;
  logic              w_seq_gnt;
  logic [ADDR_W-1:0] w_seq_addr;
  logic [DATA_W-1:0] w_seq_data;
  logic [16:0]       w_sum;
  logic [16:0]       w_dif;
  logic [15:0]       w_next;
  logic              w_reg_we;
  logic [ADDR_W-1:0] w_reg_addr;
  logic [DATA_W-1:0] w_reg_data;

  // A host write to either compare1 byte takes the register back from the ramp
  assign w_host_ovr = host_bus.we &&
                      ((host_bus.addr == CMP_LO_ADDR) || (host_bus.addr == CMP_HI_ADDR));
  assign w_abort    = busy_q && (ramp_stop_i || w_host_ovr);

  // 17-bit step arithmetic; bit 16 flags overflow (up) or borrow (down)
  assign w_sum = {1'b0, value_q} + {1'b0, step_q};
  assign w_dif = {1'b0, value_q} - {1'b0, step_q};

  // Next ramp value, clamped to the end value instead of passing it or wrapping
  always_comb begin
    w_next = end_q;
    if (dir_up_q) begin
      if (!w_sum[16] && (w_sum[15:0] <= end_q)) w_next = w_sum[15:0];
    end else begin
      if (!w_dif[16] && (w_dif[15:0] >= end_q)) w_next = w_dif[15:0];
    end
  end

  // Sequencer bus request: one byte per write state, withheld once an abort is seen
  always_comb begin
    w_seq_req  = 1'b0;
    w_seq_addr = CMP_LO_ADDR;
    w_seq_data = value_q[7:0];
    if (state_q == S_WR_LO) begin
      w_seq_req = !w_abort;
    end else if (state_q == S_WR_HI) begin
      w_seq_req  = !w_abort;
      w_seq_addr = CMP_HI_ADDR;
      w_seq_data = value_q[15:8];
    end
  end

  reg_bus_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .host_we_i   (host_bus.we),
    .host_addr_i (host_bus.addr),
    .host_data_i (host_bus.data),
    .seq_req_i   (w_seq_req),
    .seq_addr_i  (w_seq_addr),
    .seq_data_i  (w_seq_data),
    .seq_gnt_o   (w_seq_gnt),
    .reg_we_o    (w_reg_we),
    .reg_addr_o  (w_reg_addr),
    .reg_data_o  (w_reg_data)
  );

  assign reg_bus.we   = w_reg_we;
  assign reg_bus.addr = w_reg_addr;
  assign reg_bus.data = w_reg_data;

  // Ramp FSM next-state: launch, write pair, hold for periods, step, with abort override
  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    end_d       = end_q;
    step_d      = step_q;
    hold_cfg_d  = hold_cfg_q;
    hold_cnt_d  = hold_cnt_q;
    dir_up_d    = dir_up_q;
    busy_d      = busy_q;
    cur_value_d = cur_value_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ramp_start_i && !ramp_stop_i) begin
          value_d    = cfg_start_i;
          end_d      = cfg_end_i;
          step_d     = cfg_step_i;
          hold_cfg_d = cfg_hold_i;
          dir_up_d   = (cfg_end_i > cfg_start_i);
          busy_d     = 1'b1;
          state_d    = S_WR_LO;
        end
      end
      S_WR_LO: begin
        if (w_seq_gnt) state_d = S_WR_HI;
      end
      S_WR_HI: begin
        if (w_seq_gnt) begin
          cur_value_d = value_q;
          if ((value_q == end_q) || (step_q == 16'd0)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            hold_cnt_d = hold_cfg_q;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (period_wrap_i) begin
          if (hold_cnt_q == '0) state_d    = S_STEP;
          else                  hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      S_STEP: begin
        value_d = w_next;
        state_d = S_WR_LO;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (w_abort) begin
      state_d   = S_IDLE;
      busy_d    = 1'b0;
      aborted_d = 1'b1;
    end
  end

  // State and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      value_q     <= '0;
      end_q       <= '0;
      step_q      <= '0;
      hold_cfg_q  <= '0;
      hold_cnt_q  <= '0;
      dir_up_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      cur_value_q <= '0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      end_q       <= end_d;
      step_q      <= step_d;
      hold_cfg_q  <= hold_cfg_d;
      hold_cnt_q  <= hold_cnt_d;
      dir_up_q    <= dir_up_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      cur_value_q <= cur_value_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;
  assign cur_value_o = cur_value_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_ramp_sequencer
//  Description : Directed self-checking bench for pwm_ramp_sequencer
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pwm_ramp_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        period_wrap = 1'b0;
  logic        ramp_start = 1'b0;
  logic        ramp_stop = 1'b0;
  logic [15:0] cfg_start = '0;
  logic [15:0] cfg_end = '0;
  logic [15:0] cfg_step = '0;
  logic [7:0]  cfg_hold = '0;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] cur_value;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int d0;
  int a0;

  logic [13:0] wlog[$];
  logic [7:0]  mem [64];

  always #5 clk = ~clk;

  pwm_ramp_sequencer_if #(.ADDR_W(6), .DATA_W(8)) host_bus ();
  pwm_ramp_sequencer_if #(.ADDR_W(6), .DATA_W(8)) reg_bus ();

  pwm_ramp_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host_bus      (host_bus),
    .reg_bus       (reg_bus),
    .period_wrap_i (period_wrap),
    .ramp_start_i  (ramp_start),
    .ramp_stop_i   (ramp_stop),
    .cfg_start_i   (cfg_start),
    .cfg_end_i     (cfg_end),
    .cfg_step_i    (cfg_step),
    .cfg_hold_i    (cfg_hold),
    .busy_o        (busy),
    .done_o        (done),
    .aborted_o     (aborted),
    .cur_value_o   (cur_value)
  );

  // Register-file model and pulse counters, sampled on the falling edge
  always @(negedge clk) begin
    if (reg_bus.we) begin
      wlog.push_back({reg_bus.addr, reg_bus.data});
      mem[reg_bus.addr] = reg_bus.data;
    end
    if (done)    done_cnt++;
    if (aborted) abort_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] log_at(input int i);
    if (i < wlog.size()) return wlog[i];
    return 14'h3FFF;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic wrap_n(input int len);
    period_wrap = 1'b1;
    repeat (len) cyc();
    period_wrap = 1'b0;
  endtask

  task automatic ramp(input logic [15:0] s, input logic [15:0] e,
                      input logic [15:0] st, input logic [7:0] h);
    cfg_start  = s;
    cfg_end    = e;
    cfg_step   = st;
    cfg_hold   = h;
    ramp_start = 1'b1;
    cyc();
    ramp_start = 1'b0;
  endtask

  initial begin
    host_bus.we   = 1'b0;
    host_bus.addr = '0;
    host_bus.data = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;

    // Reset state
    #2 rst_n = 1'b0;
    idle(3);
    check("rst_busy",    {31'd0, busy},       32'd0);
    check("rst_done",    {31'd0, done},       32'd0);
    check("rst_aborted", {31'd0, aborted},    32'd0);
    check("rst_cur",     {16'd0, cur_value},  32'd0);
    check("rst_we",      {31'd0, reg_bus.we}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Up ramp 2 -> 6 step 2, hold 0
    wlog.delete(); d0 = done_cnt;
    ramp(16'd2, 16'd6, 16'd2, 8'd0);
    idle(4);
    check("up_busy",   {31'd0, busy}, 32'd1);
    check("up_lo0",    {18'd0, log_at(0)}, {18'd0, 6'h03, 8'h02});
    check("up_hi0",    {18'd0, log_at(1)}, {18'd0, 6'h04, 8'h00});
    check("up_cur0",   {16'd0, cur_value}, 32'd2);
    wrap_n(1); idle(5);
    check("up_lo1",    {18'd0, log_at(2)}, {18'd0, 6'h03, 8'h04});
    check("up_mid_dn", done_cnt - d0, 32'd0);
    wrap_n(1); idle(5);
    check("up_lo2",    {18'd0, log_at(4)}, {18'd0, 6'h03, 8'h06});
    check("up_nlog",   wlog.size(), 32'd6);
    check("up_done",   done_cnt - d0, 32'd1);
    check("up_cur",    {16'd0, cur_value}, 32'd6);
    check("up_idle",   {31'd0, busy}, 32'd0);

    // Saturating down ramp 5 -> 0 step 3
    wlog.delete(); d0 = done_cnt;
    ramp(16'd5, 16'd0, 16'd3, 8'd0);
    idle(4); wrap_n(1); idle(5); wrap_n(1); idle(5);
    check("dn_lo0",  {18'd0, log_at(0)}, {18'd0, 6'h03, 8'h05});
    check("dn_lo1",  {18'd0, log_at(2)}, {18'd0, 6'h03, 8'h02});
    check("dn_lo2",  {18'd0, log_at(4)}, {18'd0, 6'h03, 8'h00});
    check("dn_hi2",  {18'd0, log_at(5)}, {18'd0, 6'h04, 8'h00});
    check("dn_done", done_cnt - d0, 32'd1);
    check("dn_cur",  {16'd0, cur_value}, 32'd0);

    // Saturating up ramp 0xFFF0 -> 0xFFFF step 0x20
    wlog.delete(); d0 = done_cnt;
    ramp(16'hFFF0, 16'hFFFF, 16'h0020, 8'd0);
    idle(4); wrap_n(1); idle(5);
    check("sat_lo0",  {18'd0, log_at(0)}, {18'd0, 6'h03, 8'hF0});
    check("sat_lo1",  {18'd0, log_at(2)}, {18'd0, 6'h03, 8'hFF});
    check("sat_cur",  {16'd0, cur_value}, 32'h0000FFFF);
    check("sat_done", done_cnt - d0, 32'd1);

    // Hold count 2: three wraps per step, wraps outside WAIT ignored
    wlog.delete(); d0 = done_cnt;
    ramp(16'h0010, 16'h0030, 16'h0010, 8'd2);
    idle(4);
    wrap_n(1); idle(2); wrap_n(1); idle(2);
    check("hold_2w",   wlog.size(), 32'd2);
    wrap_n(4); idle(2);
    check("hold_3w",   wlog.size(), 32'd4);
    check("hold_lo1",  {18'd0, log_at(2)}, {18'd0, 6'h03, 8'h20});
    wrap_n(1); idle(2); wrap_n(1); idle(2);
    check("hold_ign",  wlog.size(), 32'd4);
    wrap_n(1); idle(5);
    check("hold_fin",  wlog.size(), 32'd6);
    check("hold_cur",  {16'd0, cur_value}, 32'h00000030);
    check("hold_done", done_cnt - d0, 32'd1);

    // Host write to PERIOD collides with sequencer WR_LO, then ramp_stop in WAIT
    wlog.delete(); a0 = abort_cnt;
    ramp(16'h0123, 16'h0200, 16'h0001, 8'd0);
    host_bus.we = 1'b1; host_bus.addr = 6'h00; host_bus.data = 8'h07;
    cyc();
    host_bus.we = 1'b0;
    idle(4);
    check("hc_host",  {18'd0, log_at(0)}, {18'd0, 6'h00, 8'h07});
    check("hc_lo",    {18'd0, log_at(1)}, {18'd0, 6'h03, 8'h23});
    check("hc_hi",    {18'd0, log_at(2)}, {18'd0, 6'h04, 8'h01});
    check("hc_abort", abort_cnt - a0, 32'd0);
    ramp_stop = 1'b1; cyc(); ramp_stop = 1'b0;
    idle(3);
    check("stop_abort", abort_cnt - a0, 32'd1);
    check("stop_busy",  {31'd0, busy}, 32'd0);
    check("stop_cur",   {16'd0, cur_value}, 32'h00000123);
    check("stop_nlog",  wlog.size(), 32'd3);

    // Host override of compare1 LSB in the cycle the sequencer wants WR_LO
    wlog.delete(); a0 = abort_cnt;
    ramp(16'h0040, 16'h0080, 16'h0010, 8'd0);
    idle(4);
    wrap_n(1);
    cyc();
    host_bus.we = 1'b1; host_bus.addr = 6'h03; host_bus.data = 8'h11;
    cyc();
    host_bus.we = 1'b0;
    idle(6);
    check("ov_abort", abort_cnt - a0, 32'd1);
    check("ov_nlog",  wlog.size(), 32'd3);
    check("ov_last",  {18'd0, log_at(2)}, {18'd0, 6'h03, 8'h11});
    check("ov_mem",   {24'd0, mem[3]}, 32'h11);
    check("ov_cur",   {16'd0, cur_value}, 32'h00000040);
    check("ov_busy",  {31'd0, busy}, 32'd0);

    // start == end: single pair then done
    wlog.delete(); d0 = done_cnt;
    ramp(16'd5, 16'd5, 16'd1, 8'd0);
    idle(5);
    check("eq_nlog", wlog.size(), 32'd2);
    check("eq_done", done_cnt - d0, 32'd1);
    check("eq_busy", {31'd0, busy}, 32'd0);

    // step == 0: single pair then done
    wlog.delete(); d0 = done_cnt;
    ramp(16'd7, 16'd9, 16'd0, 8'd0);
    idle(5);
    check("s0_nlog", wlog.size(), 32'd2);
    check("s0_done", done_cnt - d0, 32'd1);
    check("s0_cur",  {16'd0, cur_value}, 32'd7);

    // Stop and start together in IDLE: start ignored, nothing aborted
    wlog.delete(); a0 = abort_cnt;
    ramp_stop = 1'b1;
    ramp(16'd1, 16'd2, 16'd1, 8'd0);
    ramp_stop = 1'b0;
    idle(4);
    check("ss_busy",  {31'd0, busy}, 32'd0);
    check("ss_nlog",  wlog.size(), 32'd0);
    check("ss_abort", abort_cnt - a0, 32'd0);

    // Reset asserted during WAIT clears outputs immediately
    wlog.delete();
    ramp(16'd1, 16'd9, 16'd1, 8'd3);
    idle(4);
    check("rw_busy_pre", {31'd0, busy}, 32'd1);
    check("rw_cur_pre",  {16'd0, cur_value}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rw_busy", {31'd0, busy}, 32'd0);
    check("rw_cur",  {16'd0, cur_value}, 32'd0);
    check("rw_we",   {31'd0, reg_bus.we}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Fresh ramp after reset
    wlog.delete(); d0 = done_cnt;
    ramp(16'd3, 16'd4, 16'd1, 8'd0);
    idle(4); wrap_n(1); idle(5);
    check("pr_lo0",  {18'd0, log_at(0)}, {18'd0, 6'h03, 8'h03});
    check("pr_lo1",  {18'd0, log_at(2)}, {18'd0, 6'h03, 8'h04});
    check("pr_cur",  {16'd0, cur_value}, 32'd4);
    check("pr_done", done_cnt - d0, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
